// File: rtl/qpsk_map.sv
// rtl/qpsk_map.sv - QPSK mapper: byte stream in, one {Q,I} symbol per output beat
//
// Parameters:
//   IQ_DW      width of each two's-complement I/Q component
//   AMPLITUDE  component magnitude, 0 < AMPLITUDE < 2^(IQ_DW-1)
// Ports:
//   clk_i, reset_ni                     clock, asynchronous active-low reset
//   s_axis_in_*   tdata[7:0]/tuser[1:0]/tlast/tvalid/tready  input byte stream
//   m_axis_out_*  tdata[2*IQ_DW-1:0]={Q,I}/tuser/tlast/tvalid/tready  symbol stream
// Configuration:
//   QPSK_MAP_MSB_FIRST_EN  when defined, symbols of a byte are emitted k=3..0
//                          (default k=0..3); tlast always marks the final one.

module qpsk_map #(
    parameter int IQ_DW     = 16,
    parameter int AMPLITUDE = 23170
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [7:0]         s_axis_in_tdata,
    input  logic [1:0]         s_axis_in_tuser,
    input  logic               s_axis_in_tlast,
    input  logic               s_axis_in_tvalid,
    output logic               s_axis_in_tready,
    output logic [2*IQ_DW-1:0] m_axis_out_tdata,
    output logic [1:0]         m_axis_out_tuser,
    output logic               m_axis_out_tlast,
    output logic               m_axis_out_tvalid,
    input  logic               m_axis_out_tready
);

    localparam logic [IQ_DW-1:0] AMP_POS = IQ_DW'(AMPLITUDE);
    localparam logic [IQ_DW-1:0] AMP_NEG = IQ_DW'(-AMPLITUDE);

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;      // number of symbols of the held byte already presented
    logic [7:0] byte_q;
    logic [1:0] user_q;
    logic       last_q;

    logic              in_xfer;
    logic              out_xfer;
    logic [7:0]        sym_byte;
    logic [1:0]        sym_user;
    logic              sym_last;
    logic [1:0]        sym_idx;
    logic [2*IQ_DW-1:0] tdata_d;
    logic              tlast_d;

    function automatic logic [2*IQ_DW-1:0] map_sym(input logic [1:0] s);
        return {(s[1] ? AMP_NEG : AMP_POS), (s[0] ? AMP_NEG : AMP_POS)};
    endfunction

    // Accept a new byte while empty, or in the very cycle the last symbol
    // leaves, so back-to-back bytes produce no bubble.
    assign s_axis_in_tready = reset_ni &&
                              ((state_q == EMPTY) || ((cnt_q == 2'd3) && m_axis_out_tready));
    assign in_xfer  = s_axis_in_tvalid && s_axis_in_tready;
    assign out_xfer = (state_q == BUSY) && m_axis_out_tready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    cnt_d   = 2'd0;
                end
            end
            BUSY: begin
                if (out_xfer) begin
                    if (cnt_q != 2'd3) begin
                        cnt_d = cnt_q + 2'd1;
                    end else if (in_xfer) begin
                        cnt_d = 2'd0;
                    end else begin
                        state_d = EMPTY;
                        cnt_d   = 2'd0;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Next symbol comes from the incoming byte when one is accepted, else from the held byte.
    always_comb begin
        sym_byte = in_xfer ? s_axis_in_tdata : byte_q;
        sym_user = in_xfer ? s_axis_in_tuser : user_q;
        sym_last = in_xfer ? s_axis_in_tlast : last_q;
`ifdef QPSK_MAP_MSB_FIRST_EN
        sym_idx  = ~cnt_d;
`else
        sym_idx  = cnt_d;
`endif
        tdata_d  = map_sym(sym_byte[{sym_idx, 1'b0} +: 2]);
        tlast_d  = sym_last && (cnt_d == 2'd3);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q             <= 2'd0;
            byte_q            <= 8'd0;
            user_q            <= 2'd0;
            last_q            <= 1'b0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tuser  <= 2'd0;
            m_axis_out_tlast  <= 1'b0;
            m_axis_out_tvalid <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (in_xfer) begin
                byte_q <= s_axis_in_tdata;
                user_q <= s_axis_in_tuser;
                last_q <= s_axis_in_tlast;
            end
            // Output registers only move on a load or a completed output beat,
            // which keeps them stable under backpressure.
            if (in_xfer || out_xfer) begin
                m_axis_out_tvalid <= (state_d == BUSY);
                if (state_d == BUSY) begin
                    m_axis_out_tdata <= tdata_d;
                    m_axis_out_tuser <= sym_user;
                    m_axis_out_tlast <= tlast_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_qpsk_map.sv
// tb/tb_qpsk_map.sv - self-checking bench for qpsk_map

module tb_qpsk_map;

    localparam int IQ_DW = 16;
    localparam int AMP   = 23170;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic [7:0]        s_tdata;
    logic [1:0]        s_tuser;
    logic              s_tlast;
    logic              s_tvalid;
    logic              s_tready;
    logic [2*IQ_DW-1:0] m_tdata;
    logic [1:0]        m_tuser;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;

    qpsk_map #(.IQ_DW(IQ_DW), .AMPLITUDE(AMP)) dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .s_axis_in_tdata   (s_tdata),
        .s_axis_in_tuser   (s_tuser),
        .s_axis_in_tlast   (s_tlast),
        .s_axis_in_tvalid  (s_tvalid),
        .s_axis_in_tready  (s_tready),
        .m_axis_out_tdata  (m_tdata),
        .m_axis_out_tuser  (m_tuser),
        .m_axis_out_tlast  (m_tlast),
        .m_axis_out_tvalid (m_tvalid),
        .m_axis_out_tready (m_tready)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  user;
        logic        last;
    } sym_t;

    sym_t        mq[$];
    logic [31:0] got[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          held = 0;
    logic [31:0] held_data;
    logic [1:0]  held_user;
    logic        held_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: each accepted byte becomes four symbols by plain arithmetic.
    task automatic model_push(input logic [7:0] d, input logic [1:0] u, input logic l);
        for (int n = 0; n < 4; n++) begin
            sym_t s;
            int k, b0, b1, iv, qv;
            logic [31:0] iw, qw;
`ifdef QPSK_MAP_MSB_FIRST_EN
            k = 3 - n;
`else
            k = n;
`endif
            b0 = (int'(d) / (1 << (2 * k))) % 2;
            b1 = (int'(d) / (1 << (2 * k + 1))) % 2;
            iv = b0 ? -AMP : AMP;
            qv = b1 ? -AMP : AMP;
            iw = iv;
            qw = qv;
            s.data = {qw[15:0], iw[15:0]};
            s.user = u;
            s.last = l && (n == 3);
            mq.push_back(s);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input logic [1:0] u,
                        input bit l, input bit r, output bit accepted);
        bit exp_rdy;
        @(negedge clk_i);
        s_tvalid = v; s_tdata = d; s_tuser = u; s_tlast = l; m_tready = r;
        #1;
        exp_rdy = (mq.size() == 0) || (mq.size() == 1 && r);
        chk("tvalid", {31'd0, m_tvalid}, {31'd0, mq.size() != 0});
        chk("s_tready", {31'd0, s_tready}, {31'd0, exp_rdy});
        if (held) begin
            chk("stall_data", m_tdata, held_data);
            chk("stall_user", {30'd0, m_tuser}, {30'd0, held_user});
            chk("stall_last", {31'd0, m_tlast}, {31'd0, held_last});
        end
        if (m_tvalid && r && mq.size() > 0) begin
            sym_t e;
            e = mq.pop_front();
            chk("tdata", m_tdata, e.data);
            chk("tuser", {30'd0, m_tuser}, {30'd0, e.user});
            chk("tlast", {31'd0, m_tlast}, {31'd0, e.last});
            got.push_back(m_tdata);
        end
        accepted = v && s_tready;
        if (accepted) model_push(d, u, l);
        held = m_tvalid && !r;
        held_data = m_tdata; held_user = m_tuser; held_last = m_tlast;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] u, input bit l, input bit r);
        bit acc = 0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, d, u, l, r, acc);
        chk("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, acc);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tuser", {30'd0, m_tuser}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    endtask

    logic [31:0] exp_1b[4];
    bit          acc;

    initial begin
`ifdef QPSK_MAP_MSB_FIRST_EN
        exp_1b = '{32'h5A825A82, 32'h5A82A57E, 32'hA57E5A82, 32'hA57EA57E};
`else
        exp_1b = '{32'hA57EA57E, 32'hA57E5A82, 32'h5A82A57E, 32'h5A825A82};
`endif
        reset_ni = 1'b0;
        s_tvalid = 0; s_tdata = 0; s_tuser = 0; s_tlast = 0; m_tready = 0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;

        // Byte 0x1B, downstream always ready
        got.delete();
        send(8'h1B, 2'b00, 1'b0, 1'b1);
        idle(6);
        chk("n_1b", got.size(), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("lit_1b", got[i], exp_1b[i]);

        // 0x00 then 0xFF back-to-back, tlast on the second
        got.delete();
        send(8'h00, 2'b00, 1'b0, 1'b1);
        send(8'hFF, 2'b00, 1'b1, 1'b1);
        idle(8);
        chk("n_00ff", got.size(), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("lit_00ff", got[i], (i < 4) ? 32'h5A825A82 : 32'hA57EA57E);

        // Backpressure mid-byte
        send(8'hC6, 2'b11, 1'b1, 1'b1);
        step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, acc);
        repeat (3) step(1'b1, 8'h5A, 2'b01, 1'b0, 1'b0, acc);
        idle(6);

        // tuser propagation on consecutive bytes
        send(8'h39, 2'b10, 1'b0, 1'b1);
        send(8'h93, 2'b01, 1'b0, 1'b1);
        idle(8);

        // Reset after two symbols of 0x1B
        send(8'h1B, 2'b00, 1'b0, 1'b1);
        idle(2);
        reset_ni = 1'b0;
        #1;
        chk_reset_outputs();
        mq.delete();
        held = 0;
        @(negedge clk_i);
        chk_reset_outputs();
        reset_ni = 1'b1;
        got.delete();
        send(8'hFF, 2'b00, 1'b0, 1'b1);
        idle(8);
        chk("n_after_rst", got.size(), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("lit_ff", got[i], 32'hA57EA57E);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 8'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom % 4) != 0, acc);
        idle(8);
        chk("drained", mq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
